// File: rtl/tipi_pi_regbank.sv
// tipi_pi_regbank: register bank shared between the TI decode port and the Raspberry Pi
// nibble-serial link on the TIPI PEB card.
//
// Each of NREGS registers (DATA_W bits) has exactly one writer: the TI side when its
// TI_OWN bit is 1, the Pi side otherwise. The Pi moves a register as a framed transfer:
// r_le high for the frame, one command nibble on the first r_clk rise
// ({write, idx[2:0]}), then DATA_W/4 data nibbles, most significant first.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   ti_wr_en/ti_idx/ti_wr_data   TI write strobe, register index, write data
//   ti_rd_data              combinational contents of register ti_idx (0 if out of range)
//   ti_err_clr              clears the sticky pi_err flag
//   irq_mask, irq           per-register enables and the resulting change interrupt
//   r_clk, r_le, r_nib_in   asynchronous Pi shift clock, frame enable, nibble input
//   r_nib_out, r_nib_oe     nibble and pad output enable driven toward the Pi
//   pi_err                  sticky illegal Pi access flag
//   changed                 per-register change flags
module tipi_pi_regbank #(
  parameter int unsigned       NREGS  = 4,
  parameter int unsigned       DATA_W = 8,
  parameter logic [NREGS-1:0]  TI_OWN = 4'b0011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ti_wr_en,
  input  logic [2:0]        ti_idx,
  input  logic [DATA_W-1:0] ti_wr_data,
  output logic [DATA_W-1:0] ti_rd_data,
  input  logic              ti_err_clr,
  input  logic [NREGS-1:0]  irq_mask,
  output logic              irq,
  input  logic              r_clk,
  input  logic              r_le,
  input  logic [3:0]        r_nib_in,
  output logic [3:0]        r_nib_out,
  output logic              r_nib_oe,
  output logic              pi_err,
  output logic [NREGS-1:0]  changed
);

  localparam int unsigned NIBS  = DATA_W / 4;
  localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

  // Ownership and existence padded to the full 3-bit index space so any idx can be tested.
  localparam logic [7:0] OWN   = 8'(TI_OWN);
  localparam logic [7:0] VALID = 8'((16'd1 << NREGS) - 16'd1);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} pi_state_e;

  pi_state_e         state_q, state_d;
  logic              wr_q, wr_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              oe_q, oe_d;
  logic              commit_q, commit_d;
  logic              err_q, err_d;
  logic [NREGS-1:0]  changed_q, changed_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_ext [8];

  // bit0/bit1 are the synchroniser stages, bit2 holds the previous synchronised level.
  logic [2:0] rclk_q, rle_q;
  logic       clk_rise, le_rise, le_fall;

  logic [7:0] pi_set, pi_clr;
  logic       pi_err_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rclk_q <= '0;
      rle_q  <= '0;
    end else begin
      rclk_q <= {rclk_q[1:0], r_clk};
      rle_q  <= {rle_q[1:0], r_le};
    end
  end

  assign clk_rise = rclk_q[1] & ~rclk_q[2];
  assign le_rise  = rle_q[1] & ~rle_q[2];
  assign le_fall  = ~rle_q[1] & rle_q[2];

  always_comb begin
    for (int n = 0; n < 8; n++) regs_ext[n] = '0;
    for (int n = 0; n < int'(NREGS); n++) regs_ext[n] = regs_q[n];
  end

  assign ti_rd_data = regs_ext[ti_idx];

  // Pi frame FSM: next state, shadow datapath and Pi-side flag events.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    oe_d       = oe_q;
    commit_d   = 1'b0;
    pi_set     = '0;
    pi_clr     = '0;
    pi_err_set = 1'b0;

    // Commit lands one clk after the last nibble; it is independent of the frame state.
    if (commit_q) begin
      if (VALID[idx_q] && !OWN[idx_q]) pi_set[idx_q] = 1'b1;
      else                             pi_err_set    = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (le_rise) state_d = StCmd;
      end
      StCmd: begin
        if (le_fall) begin
          state_d = StIdle;
        end else if (clk_rise) begin
          wr_d    = r_nib_in[3];
          idx_d   = r_nib_in[2:0];
          cnt_d   = '0;
          state_d = StData;
          if (!r_nib_in[3]) begin
            // Read: snapshot now so the first nibble is on the pins one clk later.
            shadow_d = regs_ext[r_nib_in[2:0]];
            oe_d     = 1'b1;
            if (!VALID[r_nib_in[2:0]])  pi_err_set             = 1'b1;
            else if (OWN[r_nib_in[2:0]]) pi_clr[r_nib_in[2:0]] = 1'b1;
          end
        end
      end
      StData: begin
        if (le_fall) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end else if (clk_rise) begin
          if (wr_q) begin
            shadow_d = DATA_W'({shadow_q, r_nib_in});
          end else if (cnt_q != LAST_NIB) begin
            shadow_d = DATA_W'({shadow_q, 4'h0});
          end
          if (cnt_q == LAST_NIB) begin
            state_d  = StDone;
            commit_d = wr_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        if (le_fall) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file, change flags and error flag. Ownership guarantees at most one writer.
  always_comb begin
    for (int n = 0; n < int'(NREGS); n++) begin
      logic ti_hit, ti_sel, set_n, clr_n;
      ti_hit = (ti_idx == 3'(n));
      ti_sel = ti_wr_en && ti_hit && OWN[n];
      regs_d[n] = regs_q[n];
      if (ti_sel)         regs_d[n] = ti_wr_data;
      else if (pi_set[n]) regs_d[n] = shadow_q;
      set_n = ti_sel | pi_set[n];
      // Pi-owned flags are consumed by the TI selecting them on a non-write cycle.
      clr_n = pi_clr[n] | (!ti_wr_en && !ti_err_clr && ti_hit && !OWN[n]);
      changed_d[n] = set_n | (changed_q[n] & ~clr_n);
    end
    err_d = pi_err_set | (err_q & ~ti_err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      oe_q      <= 1'b0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
      changed_q <= '0;
      for (int n = 0; n < int'(NREGS); n++) regs_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      oe_q      <= oe_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
      changed_q <= changed_d;
      for (int n = 0; n < int'(NREGS); n++) regs_q[n] <= regs_d[n];
    end
  end

  assign r_nib_oe  = oe_q;
  assign r_nib_out = oe_q ? shadow_q[DATA_W-1 -: 4] : 4'h0;
  assign pi_err    = err_q;
  assign changed   = changed_q;
  assign irq       = |(changed_q & irq_mask & ~TI_OWN);

endmodule

// File: tb/tb_tipi_pi_regbank.sv
// Directed bench for tipi_pi_regbank with default parameters (4 regs, 8 bits, TI owns 0 and 1).
module tb_tipi_pi_regbank;

  logic       clk = 1'b0;
  logic       reset;
  logic       ti_wr_en;
  logic [2:0] ti_idx;
  logic [7:0] ti_wr_data;
  logic [7:0] ti_rd_data;
  logic       ti_err_clr;
  logic [3:0] irq_mask;
  logic       irq;
  logic       r_clk;
  logic       r_le;
  logic [3:0] r_nib_in;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic       pi_err;
  logic [3:0] changed;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  tipi_pi_regbank #(
    .NREGS  (4),
    .DATA_W (8),
    .TI_OWN (4'b0011)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ti_wr_en   (ti_wr_en),
    .ti_idx     (ti_idx),
    .ti_wr_data (ti_wr_data),
    .ti_rd_data (ti_rd_data),
    .ti_err_clr (ti_err_clr),
    .irq_mask   (irq_mask),
    .irq        (irq),
    .r_clk      (r_clk),
    .r_le       (r_le),
    .r_nib_in   (r_nib_in),
    .r_nib_out  (r_nib_out),
    .r_nib_oe   (r_nib_oe),
    .pi_err     (pi_err),
    .changed    (changed)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ti_write(input logic [2:0] idx, input logic [7:0] data);
    ti_idx     = idx;
    ti_wr_data = data;
    ti_wr_en   = 1'b1;
    clks(1);
    ti_wr_en   = 1'b0;
    ti_idx     = 3'd7;
  endtask

  task automatic ti_peek(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    ti_idx = idx;
    #1;
    check_eq(tag, 32'(ti_rd_data), 32'(exp));
  endtask

  // One r_clk pulse, nibble held across the whole pulse; edges act 3 clks after the pin.
  task automatic pi_nib(input logic [3:0] nib);
    r_nib_in = nib;
    r_clk    = 1'b1;
    clks(5);
    r_clk    = 1'b0;
    clks(5);
  endtask

  task automatic pi_le(input logic v);
    r_le = v;
    clks(5);
  endtask

  initial begin
    reset = 1'b1; ti_wr_en = 1'b0; ti_idx = 3'd7; ti_wr_data = '0; ti_err_clr = 1'b0;
    irq_mask = '0; r_clk = 1'b0; r_le = 1'b0; r_nib_in = '0;
    clks(3);
    for (int i = 0; i < 4; i++) ti_peek("rst_rd", 3'(i), 8'h00);
    check_eq("rst_oe", 32'(r_nib_oe), 0);
    check_eq("rst_nib", 32'(r_nib_out), 0);
    check_eq("rst_err", 32'(pi_err), 0);
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_chg", 32'(changed), 0);
    reset = 1'b0; ti_idx = 3'd7;
    clks(2);

    // TI write, then Pi read of the same TI-owned register.
    ti_write(3'd0, 8'hA5);
    ti_peek("tiw_rd0", 3'd0, 8'hA5);
    check_eq("tiw_chg", 32'(changed), 32'h1);
    ti_idx = 3'd7;
    pi_le(1'b1);
    pi_nib(4'h0);
    check_eq("rd_oe0", 32'(r_nib_oe), 1);
    check_eq("rd_nib0", 32'(r_nib_out), 32'hA);
    check_eq("rd_chg", 32'(changed), 0);
    pi_nib(4'h0);
    check_eq("rd_nib1", 32'(r_nib_out), 32'h5);
    pi_nib(4'h0);
    check_eq("rd_hold", 32'(r_nib_out), 32'h5);
    check_eq("rd_oe_hold", 32'(r_nib_oe), 1);
    pi_le(1'b0);
    check_eq("rd_oe_off", 32'(r_nib_oe), 0);

    // Pi write to Pi-owned reg 2 raising irq.
    irq_mask = 4'b0100;
    pi_le(1'b1);
    pi_nib(4'hA);
    pi_nib(4'h3);
    pi_nib(4'hC);
    check_eq("pw_chg", 32'(changed), 32'h4);
    check_eq("pw_irq", 32'(irq), 1);
    pi_le(1'b0);
    ti_peek("pw_rd2", 3'd2, 8'h3C);
    clks(1);
    check_eq("pw_chg_clr", 32'(changed), 0);
    check_eq("pw_irq_clr", 32'(irq), 0);
    ti_idx = 3'd7;

    // Illegal Pi write to TI-owned reg 0.
    pi_le(1'b1);
    pi_nib(4'h8);
    pi_nib(4'hF);
    pi_nib(4'hF);
    pi_le(1'b0);
    check_eq("ill_err", 32'(pi_err), 1);
    ti_peek("ill_rd0", 3'd0, 8'hA5);
    ti_idx = 3'd7;
    ti_err_clr = 1'b1;
    clks(1);
    ti_err_clr = 1'b0;
    check_eq("ill_errclr", 32'(pi_err), 0);

    // Illegal TI write to Pi-owned reg 2 is ignored silently.
    ti_write(3'd2, 8'hFF);
    ti_peek("tiill_rd2", 3'd2, 8'h3C);
    check_eq("tiill_err", 32'(pi_err), 0);
    ti_idx = 3'd7;

    // Pi read of a nonexistent register.
    pi_le(1'b1);
    pi_nib(4'h5);
    check_eq("oor_oe", 32'(r_nib_oe), 1);
    check_eq("oor_nib", 32'(r_nib_out), 0);
    check_eq("oor_err", 32'(pi_err), 1);
    pi_nib(4'h0);
    pi_nib(4'h0);
    pi_le(1'b0);
    ti_err_clr = 1'b1;
    clks(1);
    ti_err_clr = 1'b0;

    // Aborted write to reg 3, then a full one.
    pi_le(1'b1);
    pi_nib(4'hB);
    pi_nib(4'h7);
    pi_le(1'b0);
    check_eq("ab_chg", 32'(changed), 0);
    ti_peek("ab_rd3", 3'd3, 8'h00);
    ti_idx = 3'd7;
    clks(2);
    pi_le(1'b1);
    pi_nib(4'hB);
    pi_nib(4'h9);
    pi_nib(4'h6);
    check_eq("ab2_chg", 32'(changed), 32'h8);
    check_eq("ab2_irq_masked", 32'(irq), 0);
    pi_le(1'b0);
    ti_peek("ab2_rd3", 3'd3, 8'h96);
    ti_idx = 3'd7;

    // Reset between the two data nibbles of a write to reg 2.
    pi_le(1'b1);
    pi_nib(4'hA);
    pi_nib(4'h1);
    reset = 1'b1;
    #1;
    check_eq("mr_oe", 32'(r_nib_oe), 0);
    check_eq("mr_nib", 32'(r_nib_out), 0);
    check_eq("mr_err", 32'(pi_err), 0);
    check_eq("mr_irq", 32'(irq), 0);
    check_eq("mr_chg", 32'(changed), 0);
    ti_peek("mr_rd3", 3'd3, 8'h00);
    clks(2);
    reset = 1'b0;
    r_le  = 1'b0;
    clks(6);
    ti_peek("mr_rd2", 3'd2, 8'h00);
    ti_idx = 3'd7;
    pi_le(1'b1);
    pi_nib(4'hA);
    pi_nib(4'h5);
    pi_nib(4'hA);
    pi_le(1'b0);
    ti_peek("mr_rd2_new", 3'd2, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
